sobel_tile_sequencer: RTL and testbench

//  Sequences the 5x5-window Sobel gradient unit over a full frame. Fetches each 5x5 window

---
 rtl/sobel_tile_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sobel_tile_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_tile_sequencer.sv
// Walks 5x5 windows over a frame (stride 3), feeds each to the Sobel unit and offers the 3x3 tile downstream.
// Optional Sobel handshake watchdog: define SOBEL_SEQ_TIMEOUT_EN.
module sobel_tile_sequencer #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic [199:0]      win_flat,
    output logic              sobel_start,
    input  logic              sobel_q,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [7:0]        tile_x,
    output logic [7:0]        tile_y,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);
    localparam int unsigned OX_MAX = IMG_W - 5;
    localparam int unsigned OY_MAX = IMG_H - 5;

    typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT_Q, PRESENT, DRAIN, DONE} state_e;

    state_e            state_q;
    logic [7:0]        ox_q, oy_q, ox_d, oy_d;
    logic [2:0]        fr_q, fc_q, fr_d, fc_d;   // window row/col of the read on ram_addr
    logic [4:0]        cnt_q;                    // FETCH cycle index, 0..25
    logic              last_win_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_rd_q, sobel_start_q, tile_valid_q, busy_q, frame_done_q;
    logic [199:0]      win_q;
    logic [7:0]        tile_x_q, tile_y_q;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] y, input logic [7:0] x,
                                                   input logic [2:0] r, input logic [2:0] c);
        return ADDR_W'((32'(y) + 32'(r)) * IMG_W + 32'(x) + 32'(c));
    endfunction

    // Next window origin; the last column/row is clamped so it may overlap the previous tile.
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        if (32'(ox_q) == OX_MAX) begin
            ox_d = '0;
            oy_d = (32'(oy_q) + 32'd3 > OY_MAX) ? 8'(OY_MAX) : oy_q + 8'd3;
        end else begin
            ox_d = (32'(ox_q) + 32'd3 > OX_MAX) ? 8'(OX_MAX) : ox_q + 8'd3;
        end
        last_win_d = (32'(ox_q) == OX_MAX) && (32'(oy_q) == OY_MAX);
        fr_d = (fc_q == 3'd4) ? fr_q + 3'd1 : fr_q;
        fc_d = (fc_q == 3'd4) ? 3'd0 : fc_q + 3'd1;
    end

`ifdef SOBEL_SEQ_TIMEOUT_EN
    logic [3:0] to_q;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ox_q          <= '0;
            oy_q          <= '0;
            fr_q          <= '0;
            fc_q          <= '0;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_rd_q      <= 1'b0;
            win_q         <= '0;
            sobel_start_q <= 1'b0;
            tile_valid_q  <= 1'b0;
            tile_x_q      <= '0;
            tile_y_q      <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
            to_q          <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        ox_q       <= '0;
                        oy_q       <= '0;
                        fr_q       <= '0;
                        fc_q       <= '0;
                        cnt_q      <= '0;
                        ram_rd_q   <= 1'b1;
                        ram_addr_q <= '0;
                    end
                end
                // Read k issued in cycle k lands on ram_data in cycle k+1.
                FETCH: begin
                    for (int k = 0; k < 25; k++) begin
                        if (cnt_q == 5'(k + 1)) win_q[8*k +: 8] <= ram_data;
                    end
                    if (cnt_q == 5'd25) begin
                        state_q       <= LAUNCH;
                        sobel_start_q <= 1'b1;
`ifdef SOBEL_SEQ_TIMEOUT_EN
                        to_q          <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd24) begin
                            ram_rd_q <= 1'b0;
                        end else begin
                            fr_q       <= fr_d;
                            fc_q       <= fc_d;
                            ram_addr_q <= pix_addr(oy_q, ox_q, fr_d, fc_d);
                        end
                    end
                end
                LAUNCH: state_q <= WAIT_Q;
                WAIT_Q: begin
                    if (sobel_q) begin
                        state_q      <= PRESENT;
                        tile_valid_q <= 1'b1;
                        tile_x_q     <= ox_q;
                        tile_y_q     <= oy_q;
                    end
`ifdef SOBEL_SEQ_TIMEOUT_EN
                    else if (to_q == 4'hF) begin
                        state_q       <= IDLE;
                        err_q         <= 1'b1;
                        sobel_start_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end else begin
                        to_q <= to_q + 4'd1;
                    end
`endif
                end
                PRESENT: begin
                    if (tile_ready) begin
                        state_q       <= DRAIN;
                        tile_valid_q  <= 1'b0;
                        sobel_start_q <= 1'b0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
                        to_q          <= '0;
`endif
                    end
                end
                // Never relaunch while the Sobel unit still reports the old done.
                DRAIN: begin
                    if (!sobel_q) begin
                        if (last_win_d) begin
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q    <= FETCH;
                            ox_q       <= ox_d;
                            oy_q       <= oy_d;
                            fr_q       <= '0;
                            fc_q       <= '0;
                            cnt_q      <= '0;
                            ram_rd_q   <= 1'b1;
                            ram_addr_q <= pix_addr(oy_d, ox_d, 3'd0, 3'd0);
                        end
                    end
`ifdef SOBEL_SEQ_TIMEOUT_EN
                    else if (to_q == 4'hF) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        to_q <= to_q + 4'd1;
                    end
`endif
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_rd      = ram_rd_q;
    assign win_flat    = win_q;
    assign sobel_start = sobel_start_q;
    assign tile_valid  = tile_valid_q;
    assign tile_x      = tile_x_q;
    assign tile_y      = tile_y_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sobel_tile_sequencer.sv
// Directed bench: 8x8 frame (instance a) and 9x5 overlapping frame (instance b) with RAM and Sobel models.
module tb_sobel_tile_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         frame_start_a = 1'b0, frame_start_b = 1'b0;
    logic [7:0]   ram_addr_a, ram_addr_b;
    logic         ram_rd_a, ram_rd_b;
    logic [7:0]   ram_data_a = '0, ram_data_b = '0;
    logic [199:0] win_a, win_b;
    logic         start_a, start_b;
    logic         sq_a = 1'b0, sq_b = 1'b0;
    logic         tile_valid_a, tile_valid_b;
    logic         tile_ready_a = 1'b1, tile_ready_b = 1'b1;
    logic [7:0]   tx_a, ty_a, tx_b, ty_b;
    logic         busy_a, busy_b, done_a, done_b, err_a, err_b;

    sobel_tile_sequencer #(.IMG_W(8), .IMG_H(8), .ADDR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start_a), .ram_addr(ram_addr_a),
        .ram_rd(ram_rd_a), .ram_data(ram_data_a), .win_flat(win_a), .sobel_start(start_a),
        .sobel_q(sq_a), .tile_valid(tile_valid_a), .tile_ready(tile_ready_a), .tile_x(tx_a),
        .tile_y(ty_a), .busy(busy_a), .frame_done(done_a), .err(err_a));

    sobel_tile_sequencer #(.IMG_W(9), .IMG_H(5), .ADDR_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start_b), .ram_addr(ram_addr_b),
        .ram_rd(ram_rd_b), .ram_data(ram_data_b), .win_flat(win_b), .sobel_start(start_b),
        .sobel_q(sq_b), .tile_valid(tile_valid_b), .tile_ready(tile_ready_b), .tile_x(tx_b),
        .tile_y(ty_b), .busy(busy_b), .frame_done(done_b), .err(err_b));

    // Ramp RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_rd_a) ram_data_a <= ram_addr_a;
        if (ram_rd_b) ram_data_b <= ram_addr_b;
    end

    // Sobel models: done one cycle after start; model a can stretch done or stick at 0.
    int   hold_cfg = 0, hold_left = 0;
    logic stuck = 1'b0;
    always @(posedge clk) begin
        if (stuck) sq_a <= 1'b0;
        else if (start_a) begin sq_a <= 1'b1; hold_left <= hold_cfg; end
        else if (hold_left != 0) hold_left <= hold_left - 1;
        else sq_a <= 1'b0;
        sq_b <= start_b;
    end

    int fd_a = 0, fd_b = 0;
    always @(posedge clk) begin
        if (done_a) fd_a <= fd_a + 1;
        if (done_b) fd_b <= fd_b + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [199:0] exp_win(input int w, input int ox, input int oy);
        logic [199:0] v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                v[8*(r*5+c) +: 8] = 8'((oy + r) * w + ox + c);
        return v;
    endfunction

    task automatic wait_tile(input bit sel, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (sel ? tile_valid_b : tile_valid_a) break;
            @(negedge clk);
        end
        check(tag, sel ? tile_valid_b : tile_valid_a, 1'b1);
    endtask

    task automatic pulse_a();
        frame_start_a = 1'b1;
        @(negedge clk);
        frame_start_a = 1'b0;
    endtask

    logic [7:0]   addr_log [32];
    logic [199:0] win_hold;
    int           rd_cnt, fd_before;
    bit           ok, rd_seen, sq_all;

    initial begin
        repeat (3) @(negedge clk);
        check("rst busy", busy_a, 1'b0);
        check("rst ram_rd", ram_rd_a, 1'b0);
        check("rst ram_addr", ram_addr_a, 8'd0);
        check("rst win_flat", win_a, '0);
        check("rst sobel_start", start_a, 1'b0);
        check("rst tile_valid", tile_valid_a, 1'b0);
        check("rst frame_done", done_a, 1'b0);
        check("rst err", err_a, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8x8 frame; first tile held off by tile_ready=0.
        tile_ready_a = 1'b0;
        pulse_a();
        check("busy after start", busy_a, 1'b1);
        rd_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (ram_rd_a) begin addr_log[rd_cnt[4:0]] = ram_addr_a; rd_cnt++; end
            @(negedge clk);
        end
        check("fetch read count", 32'(rd_cnt), 32'd25);
        check("fetch addr k4", addr_log[4], 8'd4);
        check("fetch addr k5", addr_log[5], 8'd8);
        check("fetch addr k24", addr_log[24], 8'd36);

        wait_tile(1'b0, "tile0 valid");
        check("tile0 x", tx_a, 8'd0);
        check("tile0 y", ty_a, 8'd0);
        check("tile0 win", win_a, exp_win(8, 0, 0));
        win_hold = win_a;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!tile_valid_a || !start_a || tx_a != 8'd0 || ty_a != 8'd0 || win_a != win_hold) ok = 1'b0;
        end
        check("present hold stable", ok, 1'b1);
        tile_ready_a = 1'b1;
        @(negedge clk);
        check("valid drop after accept", tile_valid_a, 1'b0);
        check("start drop in drain", start_a, 1'b0);

        // Second tile: Sobel done lingers after start drops.
        hold_cfg = 3;
        wait_tile(1'b0, "tile1 valid");
        check("tile1 x", tx_a, 8'd3);
        check("tile1 y", ty_a, 8'd0);
        check("tile1 win", win_a, exp_win(8, 3, 0));
        rd_seen = 1'b0;
        sq_all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ram_rd_a) rd_seen = 1'b1;
            if (!sq_a) sq_all = 1'b0;
        end
        hold_cfg = 0;
        check("sobel_q lingered", sq_all, 1'b1);
        check("no fetch on stale done", rd_seen, 1'b0);

        wait_tile(1'b0, "tile2 valid");
        check("tile2 x", tx_a, 8'd0);
        check("tile2 y", ty_a, 8'd3);
        check("tile2 win", win_a, exp_win(8, 0, 3));
        @(negedge clk);
        wait_tile(1'b0, "tile3 valid");
        check("tile3 x", tx_a, 8'd3);
        check("tile3 y", ty_a, 8'd3);
        check("tile3 win", win_a, exp_win(8, 3, 3));
        for (int i = 0; i < 50; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        check("frame_done a", done_a, 1'b1);
        check("busy low in done", busy_a, 1'b0);
        repeat (5) @(negedge clk);
        check("frame_done count a", 32'(fd_a), 32'd1);

        // Reset in the middle of a fetch.
        pulse_a();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ram_rd", ram_rd_a, 1'b0);
        check("midrst busy", busy_a, 1'b0);
        check("midrst ram_addr", ram_addr_a, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_a();
        wait_tile(1'b0, "restart valid");
        check("restart x", tx_a, 8'd0);
        check("restart y", ty_a, 8'd0);
        check("restart win", win_a, exp_win(8, 0, 0));

        // 9x5 frame: third window clamps to column 4 and overlaps.
        frame_start_b = 1'b1;
        @(negedge clk);
        frame_start_b = 1'b0;
        wait_tile(1'b1, "b tile0 valid");
        check("b tile0 xy", {tx_b, ty_b}, {8'd0, 8'd0});
        check("b tile0 win", win_b, exp_win(9, 0, 0));
        @(negedge clk);
        wait_tile(1'b1, "b tile1 valid");
        check("b tile1 xy", {tx_b, ty_b}, {8'd3, 8'd0});
        check("b tile1 win", win_b, exp_win(9, 3, 0));
        @(negedge clk);
        wait_tile(1'b1, "b tile2 valid");
        check("b tile2 xy", {tx_b, ty_b}, {8'd4, 8'd0});
        check("b overlap pixel0", win_b[7:0], 8'd4);
        check("b tile2 win", win_b, exp_win(9, 4, 0));
        for (int i = 0; i < 50; i++) begin
            if (done_b) break;
            @(negedge clk);
        end
        check("frame_done b", done_b, 1'b1);
        repeat (5) @(negedge clk);
        check("frame_done count b", 32'(fd_b), 32'd1);

`ifdef SOBEL_SEQ_TIMEOUT_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b1;
        @(negedge clk);
        fd_before = fd_a;
        pulse_a();
        for (int i = 0; i < 60; i++) begin
            if (start_a) break;
            @(negedge clk);
        end
        check("to launch", start_a, 1'b1);
        repeat (16) @(negedge clk);
        check("to err before expiry", err_a, 1'b0);
        @(negedge clk);
        check("to err set", err_a, 1'b1);
        check("to busy", busy_a, 1'b0);
        check("to start dropped", start_a, 1'b0);
        repeat (5) @(negedge clk);
        check("to err sticky", err_a, 1'b1);
        check("to no frame_done", 32'(fd_a), 32'(fd_before));
        stuck = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
